// File: rtl/data_ram.sv
// data_ram: single-port data memory answering the MEM-stage load/store bus.
// Loads return a full 32-bit word in the same cycle. Stores are posted through
// a one-entry store buffer so the array is always written from registered data;
// buffered bytes are forwarded to a following load of the same word.
// Optional feature macro: DATA_RAM_RANGE_CHECK_EN rejects accesses whose upper
// address bits are non-zero and flags them on err_o. Without it, addresses
// alias modulo the memory size and err_o is tied low.
module data_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_data,
    output logic [31:0] ram_data_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [0:DEPTH-1];
    logic                  sb_valid;
    logic [ADDR_WIDTH-1:0] sb_idx;
    logic [3:0]            sb_sel;
    logic [31:0]           sb_data;

    logic [ADDR_WIDTH-1:0] idx;
    logic                  rejected;
    logic                  unused_addr;

    assign idx = mem_addr[ADDR_WIDTH+1:2];

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign rejected = mem_ce && (mem_addr[31:ADDR_WIDTH+2] != '0);
`else
    assign rejected = 1'b0;
`endif

    // Byte offset bits never matter; upper bits only matter with the range check.
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    // Error flag is suppressed during reset.
    assign err_o = !rst && rejected;

    // Drain the buffered store into the array; runs even during reset because
    // the pipeline has already committed that store.
    always_ff @(posedge clk) begin
        if (sb_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (sb_sel[i]) begin
                    mem[sb_idx][8*i +: 8] <= sb_data[8*i +: 8];
                end
            end
        end
    end

    // Capture an accepted store into the buffer; anything else empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid <= 1'b0;
        end else if (mem_ce && mem_we && !rejected) begin
            sb_valid <= 1'b1;
            sb_idx   <= idx;
            sb_sel   <= mem_sel;
            sb_data  <= mem_data;
        end else begin
            sb_valid <= 1'b0;
        end
    end

    // Combinational load path with per-lane override from the store buffer.
    always_comb begin
        ram_data_o = '0;
        if (!rst && mem_ce && !mem_we && !rejected) begin
            ram_data_o = mem[idx];
            if (sb_valid && (sb_idx == idx)) begin
                for (int i = 0; i < 4; i++) begin
                    if (sb_sel[i]) begin
                        ram_data_o[8*i +: 8] = sb_data[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed vector table for the documented corner cases, then
// random traffic checked against an architectural memory model in which a
// store becomes visible to every later load immediately.
module tb_data_ram;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_data;
    logic [31:0] ram_data_o;
    logic        err_o;

    int n_total;
    int n_pass;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic        rst;
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t tv[$];

    data_ram #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_sel    (mem_sel),
        .mem_data   (mem_data),
        .ram_data_o (ram_data_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic out_of_range(input logic [31:0] a);
`ifdef DATA_RAM_RANGE_CHECK_EN
        return a[31:AW+2] != '0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // One bus cycle: drive, sample mid-cycle, then update the model at the edge.
    task automatic step(input logic r, input logic ce, input logic we,
                        input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        rst = r; mem_ce = ce; mem_we = we; mem_addr = a; mem_sel = s; mem_data = d;
        @(negedge clk);
        rd = ram_data_o;
        er = err_o;
        @(posedge clk);
        if (!r && ce && we && !out_of_range(a)) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
        end
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic ce, input logic we,
                                               input logic [31:0] a);
        if (r || !ce || we || out_of_range(a)) return 32'h0;
        return model_mem[widx(a)];
    endfunction

    task automatic add(input logic r, input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic [31:0] erd,
                       input logic eerr, input string name);
        vec_t v;
        v.rst = r; v.ce = ce; v.we = we; v.addr = a; v.sel = s; v.data = d;
        v.exp_rd = erd; v.exp_err = eerr; v.name = name;
        tv.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] e_rd;
        logic        e_err;
        logic [31:0] a;
        logic        r, ce, we;
        logic [3:0]  s;
        logic [31:0] d;

        n_total = 0;
        n_pass  = 0;

        // Reset state: outputs held low while rst is high, even for a load.
        step(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, rd, er);
        check("reset_rd", rd, 32'h0);
        check("reset_err", {31'h0, er}, 32'h0);

        // Give every word a known value so later expectations are defined.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 1'b1, 32'(i) << 2, 4'hF, init_val(i), rd, er);
        step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, rd, er);

        // Basic store / forward / array read
        add(0,1,1,32'h0,   4'hF,32'h11223344,32'h0,         0,"st0");
        add(0,1,0,32'h0,   4'h0,32'h0,       32'h11223344,  0,"ld0_fwd");
        add(0,0,0,32'h0,   4'h0,32'h0,       32'h0,         0,"idle_a");
        add(0,0,0,32'h0,   4'h0,32'h0,       32'h0,         0,"idle_b");
        add(0,1,0,32'h0,   4'h0,32'h0,       32'h11223344,  0,"ld0_arr");
        // Byte merge
        add(0,1,1,32'h4,   4'hF,32'h11223344,32'h0,         0,"st4");
        add(0,0,0,32'h0,   4'h0,32'h0,       32'h0,         0,"idle_c");
        add(0,0,0,32'h0,   4'h0,32'h0,       32'h0,         0,"idle_d");
        add(0,1,1,32'h5,   4'h4,32'hAAAAAAAA,32'h0,         0,"st5_byte");
        add(0,1,0,32'h4,   4'h0,32'h0,       32'h11AA3344,  0,"ld4_fwd");
        add(0,0,0,32'h0,   4'h0,32'h0,       32'h0,         0,"idle_e");
        add(0,1,0,32'h4,   4'h0,32'h0,       32'h11AA3344,  0,"ld4_arr");
        // Back-to-back stores to one word; middle bytes keep init_val(2)
        add(0,1,1,32'h8,   4'h8,32'hFFFFFFFF,32'h0,         0,"st8_a");
        add(0,1,1,32'h8,   4'h1,32'hEEEEEEEE,32'h0,         0,"st8_b");
        add(0,1,0,32'h8,   4'h0,32'h0,       32'hFFDE00EE,  0,"ld8_fwd");
        add(0,0,0,32'h0,   4'h0,32'h0,       32'h0,         0,"idle_f");
        add(0,1,0,32'h8,   4'h0,32'h0,       32'hFFDE00EE,  0,"ld8_arr");
        // Reset mid-operation: buffered store still drains
        add(0,1,1,32'hC,   4'hF,32'hCAFEBABE,32'h0,         0,"stC");
        add(1,1,0,32'hC,   4'h0,32'h0,       32'h0,         0,"ldC_in_rst");
        add(0,1,0,32'hC,   4'h0,32'h0,       32'hCAFEBABE,  0,"ldC_after");
        // Disabled access
        add(0,0,1,32'h10,  4'hF,32'hDEADBEEF,32'h0,         0,"ce0_store");
        add(0,0,0,32'h0,   4'h0,32'h0,       32'h0,         0,"idle_g");
        add(0,1,0,32'h10,  4'h0,32'h0,       32'hC0DE0004,  0,"ld10");
`ifdef DATA_RAM_RANGE_CHECK_EN
        add(0,1,1,32'h1000,4'hF,32'h12345678,32'h0,         1,"st_oor");
        add(0,1,0,32'h0,   4'h0,32'h0,       32'h11223344,  0,"ld0_after_oor");
        add(0,1,0,32'h1000,4'h0,32'h0,       32'h0,         1,"ld_oor");
`else
        add(0,1,1,32'h1000,4'hF,32'h12345678,32'h0,         0,"st_alias");
        add(0,1,0,32'h0,   4'h0,32'h0,       32'h12345678,  0,"ld0_after_alias");
        add(0,1,0,32'h1000,4'h0,32'h0,       32'h12345678,  0,"ld_alias");
`endif
        add(0,0,0,32'h1000,4'h0,32'h0,       32'h0,         0,"ce0_high_addr");

        foreach (tv[k]) begin
            step(tv[k].rst, tv[k].ce, tv[k].we, tv[k].addr, tv[k].sel, tv[k].data, rd, er);
            check({tv[k].name, "_rd"}, rd, tv[k].exp_rd);
            check({tv[k].name, "_err"}, {31'h0, er}, {31'h0, tv[k].exp_err});
        end

        // Random traffic over a small window so buffer hits are frequent.
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 31) == 0);
            ce = ($urandom_range(0, 7) != 0);
            we = $urandom_range(0, 1) == 1;
            s  = 4'($urandom);
            d  = $urandom;
            a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom) << (AW + 2));
            e_rd  = model_read(r, ce, we, a);
            e_err = !r && ce && out_of_range(a);
            step(r, ce, we, a, s, d, rd, er);
            check("rand_rd", rd, e_rd);
            check("rand_err", {31'h0, er}, {31'h0, e_err});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
